// File: rtl/fir_tap_sequencer_if.sv
// Control bundle between the FIR tap sequencer (master) and the delay-line RAM,
// coefficient ROM and shared MAC datapath (slave).
interface fir_tap_sequencer_if #(
  parameter int AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic          dl_we;
  logic          dl_wzero;
  logic [AW-1:0] dl_waddr;
  logic [AW-1:0] dl_raddr;
  logic [AW-1:0] coef_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          out_valid;
  logic          busy;
  logic          overrun;

  modport master (
    input  in_valid,
    output in_ready, dl_we, dl_wzero, dl_waddr, dl_raddr, coef_addr,
    output mac_en, mac_clr, out_valid, busy, overrun
  );

  modport slave (
    output in_valid,
    input  in_ready, dl_we, dl_wzero, dl_waddr, dl_raddr, coef_addr,
    input  mac_en, mac_clr, out_valid, busy, overrun
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Sequencer for a single-MAC FIR: clears the delay line, writes each sample,
// walks all taps through the shared MAC, waits out its pipeline and flags the result.
module fir_tap_sequencer #(
  parameter int TAPS    = 16,
  parameter int AW      = 4,
  parameter int MAC_LAT = 2
) (
  input logic                 clk,
  input logic                 reset,
  fir_tap_sequencer_if.master bus
);

  localparam int            CW         = AW + 1;
  localparam logic [CW-1:0] TAPS_C     = CW'(TAPS);
  localparam logic [CW-1:0] LAST_TAP   = CW'(TAPS - 1);
  localparam logic [CW-1:0] LAST_FLUSH = (MAC_LAT > 0) ? CW'(MAC_LAT - 1) : '0;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_MAC,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          dl_we_q, dl_we_d;
  logic          dl_wzero_q, dl_wzero_d;
  logic [AW-1:0] dl_waddr_q, dl_waddr_d;
  logic [AW-1:0] dl_raddr_q, dl_raddr_d;
  logic [AW-1:0] coef_addr_q, coef_addr_d;
  logic          mac_en_q, mac_en_d;
  logic          mac_clr_q, mac_clr_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;
  logic          in_ready;
  logic [CW-1:0] cnt_inc;
  logic [AW-1:0] wptr_inc;

  // Reset must block acceptance in the same cycle, so in_ready is gated by it directly.
  assign in_ready = ~reset & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign cnt_inc  = cnt_q + CW'(1);
  assign wptr_inc = wptr_q + AW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wptr_d      = wptr_q;
    dl_we_d     = 1'b0;
    dl_wzero_d  = 1'b0;
    dl_waddr_d  = '0;
    dl_raddr_d  = '0;
    coef_addr_d = '0;
    mac_en_d    = 1'b0;
    mac_clr_d   = 1'b0;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q | (bus.in_valid & ~in_ready);

    case (state_q)
      S_INIT: begin
        if (cnt_q == TAPS_C) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          dl_we_d    = 1'b1;
          dl_wzero_d = 1'b1;
          dl_waddr_d = cnt_q[AW-1:0];
          cnt_d      = cnt_inc;
        end
      end
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d    = S_WRITE;
          dl_we_d    = 1'b1;
          dl_waddr_d = wptr_q;
        end
      end
      S_WRITE: begin
        state_d     = S_MAC;
        cnt_d       = '0;
        mac_en_d    = 1'b1;
        mac_clr_d   = 1'b1;
        dl_raddr_d  = wptr_q;
        coef_addr_d = '0;
      end
      S_MAC: begin
        // cnt_q is the tap index being presented this cycle; outputs prepare the next one.
        if (cnt_q == LAST_TAP) begin
          cnt_d = '0;
          if (MAC_LAT == 0) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = S_FLUSH;
          end
        end else begin
          cnt_d       = cnt_inc;
          mac_en_d    = 1'b1;
          coef_addr_d = cnt_inc[AW-1:0];
          dl_raddr_d  = wptr_q - cnt_inc[AW-1:0];
        end
      end
      S_FLUSH: begin
        if (cnt_q == LAST_FLUSH) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        wptr_d = wptr_inc;
        if (bus.in_valid) begin
          state_d    = S_WRITE;
          dl_we_d    = 1'b1;
          dl_waddr_d = wptr_inc;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      wptr_q      <= '0;
      dl_we_q     <= 1'b0;
      dl_wzero_q  <= 1'b0;
      dl_waddr_q  <= '0;
      dl_raddr_q  <= '0;
      coef_addr_q <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      dl_we_q     <= dl_we_d;
      dl_wzero_q  <= dl_wzero_d;
      dl_waddr_q  <= dl_waddr_d;
      dl_raddr_q  <= dl_raddr_d;
      coef_addr_q <= coef_addr_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.dl_we     = dl_we_q;
  assign bus.dl_wzero  = dl_wzero_q;
  assign bus.dl_waddr  = dl_waddr_q;
  assign bus.dl_raddr  = dl_raddr_q;
  assign bus.coef_addr = coef_addr_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;

endmodule
